// File: rtl/enemy_ai_ctrl.sv
// Per-enemy behaviour controller: pseudo-random walk, hit points with knockback
// stun, death blanking and timed/forced respawn of one Enemy datapath instance.
module enemy_ai_ctrl #(
    parameter int          HP             = 3,
    parameter int          WALK_FRAMES    = 32,
    parameter int          STUN_FRAMES    = 16,
    parameter int          RESPAWN_FRAMES = 120,
    parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       initialize,
    input  logic       damage,
    input  logic [1:0] player_dir,
    input  logic [2:0] room,
    output logic [1:0] dir,
    output logic       active,
    output logic       stunned,
    output logic [2:0] hp,
    output logic       enemy_reset
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        WALK  = 3'd2,
        STUN  = 3'd3,
        DEAD  = 3'd4
    } state_t;

    localparam logic [2:0] HP_INIT   = 3'(HP);
    localparam logic [7:0] WALK_CNT  = 8'(WALK_FRAMES);
    localparam logic [7:0] STUN_CNT  = 8'(STUN_FRAMES);
    localparam logic [7:0] DEAD_CNT  = 8'(RESPAWN_FRAMES);

    state_t     state;
    logic [7:0] counter;
    logic [7:0] lfsr;
    logic       frame_clk_q;
    logic       damage_q;
    logic [2:0] room_q;
    logic       tick;
    logic       hit;
    logic       room_chg;

    logic [7:0] lfsr_next;
    logic [1:0] leg_dir;
    logic       spawn_now;

    assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // A new walk leg must never keep the current heading.
    assign leg_dir   = (lfsr[1:0] == dir) ? dir + 2'd1 : lfsr[1:0];
    // SPAWN always falls through to WALK, so a held initialize re-spawns every other cycle.
    assign spawn_now = ((initialize | room_chg) && state != SPAWN) ||
                       (state == DEAD && tick && counter == 8'd1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            damage_q    <= 1'b0;
            room_q      <= 3'd0;
            tick        <= 1'b0;
            hit         <= 1'b0;
            room_chg    <= 1'b0;
        end else begin
            frame_clk_q <= frame_clk;
            damage_q    <= damage;
            room_q      <= room;
            tick        <= frame_clk & ~frame_clk_q;
            hit         <= damage & ~damage_q;
            room_chg    <= (room != room_q);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            dir         <= 2'd0;
            active      <= 1'b0;
            stunned     <= 1'b0;
            hp          <= 3'd0;
            enemy_reset <= 1'b0;
            counter     <= 8'd0;
            lfsr        <= LFSR_SEED;
        end else begin
            enemy_reset <= 1'b0;
            if (tick && state != IDLE)
                lfsr <= lfsr_next;

            if (spawn_now) begin
                state       <= SPAWN;
                enemy_reset <= 1'b1;
                hp          <= HP_INIT;
                dir         <= lfsr[1:0];
                counter     <= WALK_CNT;
                active      <= 1'b0;
                stunned     <= 1'b0;
            end else begin
                case (state)
                    IDLE: active <= 1'b0;
                    SPAWN: begin
                        state  <= WALK;
                        active <= 1'b1;
                    end
                    WALK: begin
                        if (hit) begin
                            hp <= hp - 3'd1;
                            if (hp == 3'd1) begin
                                state   <= DEAD;
                                active  <= 1'b0;
                                counter <= DEAD_CNT;
                            end else begin
                                state   <= STUN;
                                dir     <= player_dir;
                                stunned <= 1'b1;
                                counter <= STUN_CNT;
                            end
                        end else if (tick) begin
                            if (counter == 8'd1) begin
                                dir     <= leg_dir;
                                counter <= WALK_CNT;
                            end else begin
                                counter <= counter - 8'd1;
                            end
                        end
                    end
                    STUN: begin
                        if (tick) begin
                            if (counter == 8'd1) begin
                                state   <= WALK;
                                stunned <= 1'b0;
                                dir     <= lfsr[1:0];
                                counter <= WALK_CNT;
                            end else begin
                                counter <= counter - 8'd1;
                            end
                        end
                    end
                    DEAD: begin
                        if (tick)
                            counter <= counter - 8'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
// Bench for enemy_ai_ctrl: scripted scenarios with a reference LFSR/behaviour
// model feeding an expected-value queue of {enemy_reset, active, stunned, hp, dir}.
module tb_enemy_ai_ctrl;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       initialize;
    logic       damage;
    logic [1:0] player_dir;
    logic [2:0] room;
    logic [1:0] dir;
    logic       active;
    logic       stunned;
    logic [2:0] hp;
    logic       enemy_reset;

    enemy_ai_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .initialize  (initialize),
        .damage      (damage),
        .player_dir  (player_dir),
        .room        (room),
        .dir         (dir),
        .active      (active),
        .stunned     (stunned),
        .hp          (hp),
        .enemy_reset (enemy_reset)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [7:0] obs;
    assign obs = {enemy_reset, active, stunned, hp, dir};

    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] m_lfsr;
    logic [1:0] m_dir;
    logic [2:0] m_hp;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] pack(input logic er, input logic a, input logic s,
                                        input logic [2:0] h, input logic [1:0] d);
        return {er, a, s, h, d};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    task automatic pulse_damage();
        damage = 1'b1;
        step();
        damage = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        Reset = 1'b1;
        frame_clk = 1'b0; initialize = 1'b0; damage = 1'b0;
        player_dir = 2'd0; room = 3'd0;
        m_lfsr = 8'hA5; m_dir = 2'd0; m_hp = 3'd0;
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
        repeat (3) step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b", obs, e);
        end
        Reset = 1'b0;
        step();
    endtask

    task automatic test_spawn();
        logic [7:0] e;
        m_dir = m_lfsr[1:0];
        m_hp  = 3'd3;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, m_hp, m_dir));
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, m_hp, m_dir));
        initialize = 1'b1;
        step();
        initialize = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL spawn_cycle: got %b expected %b", obs, e);
        end
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL spawn_walk: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_walk();
        logic [7:0] e;
        for (int k = 1; k <= 32; k++) begin
            if (k == 32)
                m_dir = (m_lfsr[1:0] == m_dir) ? m_dir + 2'd1 : m_lfsr[1:0];
            exp_q.push_back(pack(1'b0, 1'b1, 1'b0, m_hp, m_dir));
            m_lfsr = lfsr_adv(m_lfsr);
            pulse_tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL walk_tick%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic hit_into_stun(input logic [1:0] pd);
        logic [7:0] e;
        player_dir = pd;
        m_hp  = m_hp - 3'd1;
        m_dir = pd;
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, m_hp, m_dir));
        pulse_damage();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL hit_stun: got %b expected %b", obs, e);
        end
    endtask

    task automatic run_stun_ticks();
        logic [7:0] e;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16)
                m_dir = m_lfsr[1:0];
            exp_q.push_back(pack(1'b0, 1'b1, (k < 16) ? 1'b1 : 1'b0, m_hp, m_dir));
            m_lfsr = lfsr_adv(m_lfsr);
            pulse_tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL stun_tick%0d: got %b expected %b", k, obs, e);
            end
        end
    endtask

    task automatic hit_to_dead();
        logic [7:0] e;
        m_hp = 3'd0;
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, m_hp, m_dir));
        pulse_damage();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL hit_dead: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_stun();
        logic [7:0] e;
        hit_into_stun(2'd2);
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, m_hp, m_dir));
        pulse_damage();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL stun_ignores_hit: got %b expected %b", obs, e);
        end
        run_stun_ticks();
    endtask

    task automatic test_death();
        logic [7:0] e;
        hit_into_stun(2'd1);
        run_stun_ticks();
        hit_to_dead();
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, m_dir));
        pulse_damage();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL dead_ignores_hit: got %b expected %b", obs, e);
        end
        for (int k = 1; k <= 120; k++) begin
            if (k == 120) begin
                m_dir = m_lfsr[1:0];
                m_hp  = 3'd3;
                exp_q.push_back(pack(1'b1, 1'b0, 1'b0, m_hp, m_dir));
            end else begin
                exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, m_dir));
            end
            m_lfsr = lfsr_adv(m_lfsr);
            pulse_tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL dead_tick%0d: got %b expected %b", k, obs, e);
            end
        end
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, m_hp, m_dir));
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL respawn_walk: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_room_change();
        logic [7:0] e;
        hit_into_stun(2'd0);
        room = 3'd1;
        step();
        m_dir = m_lfsr[1:0];
        m_hp  = 3'd3;
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, m_hp, m_dir));
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, m_hp, m_dir));
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL room_spawn: got %b expected %b", obs, e);
        end
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL room_walk: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_same_cycle();
        logic [7:0] e;
        damage = 1'b1;
        frame_clk = 1'b1;
        step();
        initialize = 1'b1;
        frame_clk = 1'b0;
        m_dir = m_lfsr[1:0];
        m_hp  = 3'd3;
        m_lfsr = lfsr_adv(m_lfsr);
        exp_q.push_back(pack(1'b1, 1'b0, 1'b0, m_hp, m_dir));
        exp_q.push_back(pack(1'b0, 1'b1, 1'b0, m_hp, m_dir));
        step();
        initialize = 1'b0;
        damage = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL prio_spawn: got %b expected %b", obs, e);
        end
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL prio_walk: got %b expected %b", obs, e);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e;
        hit_into_stun(2'd2);
        run_stun_ticks();
        hit_into_stun(2'd3);
        run_stun_ticks();
        hit_to_dead();
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, m_dir));
            m_lfsr = lfsr_adv(m_lfsr);
            pulse_tick();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL predeath_tick%0d: got %b expected %b", k, obs, e);
            end
        end
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL async_reset_now: got %b expected %b", obs, e);
        end
        room = 3'd0;
        repeat (3) step();
        Reset = 1'b0;
        m_lfsr = 8'hA5; m_dir = 2'd0; m_hp = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 3'd0, 2'd0));
            if (k == 2)
                pulse_tick();
            else
                step();
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL idle_after_reset%0d: got %b expected %b", k, obs, e);
            end
        end
        test_spawn();
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_walk();
        test_stun();
        test_death();
        test_room_change();
        test_same_cycle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
